adc_serial_capture: RTL and testbench
=====================================

# adc_serial_capture

Parametrised multi-channel capture engine for AD7476-class serial ADCs on PMOD headers, replacing the fixed dual-channel 12-bit sampler and its wrapper. It generates one shared chip-select and serial clock, shifts in N data lines in parallel, strips and checks the leading-zero bits, and presents registered samples with a one-cycle valid strobe. It supports continuous or single-shot conversion, and its SCLK rate and quiet time are set by parameter.

## Interface
- NUM_CH, 2, number of ADC data lines sharing csn/sclk (1..8)
- DATA_W, 12, result bits per channel
- LEAD_ZEROS, 4, leading zero bits preceding data in each frame
- CLK_DIV, 4, clk cycles per SCLK half-period (>=2)
- QUIET_CYC, 8, minimum clk cycles csn held high between frames (>=1)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  1 = continuous conversion
- trig  in  1  single-cycle pulse; starts one frame when idle and enable=0
- adc_sdata  in  NUM_CH  serial data, one bit per channel
- adc_sclk  out  1  serial clock, idles high
- adc_csn  out  1  chip select, active low
- data  out  NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
- lead_err  out  NUM_CH  channel i saw a 1 in a leading-zero slot during the last frame
- data_valid  out  1  one-cycle pulse; data/lead_err updated this cycle
- busy  out  1  high from csn fall through end of quiet time

## Operation
- FRAME_BITS = LEAD_ZEROS + DATA_W (localparam).
- States: IDLE, SETUP, SHIFT, QUIET.
- IDLE: csn=1, sclk=1. Go to SETUP if enable=1, or if trig=1.
- SETUP: csn=0, sclk=1 for CLK_DIV cycles.
- SHIFT: for each of FRAME_BITS bits, sclk is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - On the clk edge that drives sclk high, every channel shifts adc_sdata in MSB-first.
  - The ADC changes data after the sclk fall, giving CLK_DIV cycles of setup.
- End of SHIFT, after the last high phase:
  - csn returns to 1.
  - The low DATA_W bits of each shift register load into data.
  - OR of the top LEAD_ZEROS bits per channel loads into lead_err.
  - data_valid=1 for one cycle.
  - Go to QUIET.
- QUIET: csn=1, sclk=1 for QUIET_CYC cycles.
  - Then go to SETUP if enable=1, else IDLE.
  - A trig seen during QUIET is not honoured.
- trig while busy: ignored. It is not queued.
- enable falling mid-frame: the current frame completes, including data_valid and QUIET, then goes to IDLE.
- enable and trig both high: one behaviour (continuous).
- data and lead_err hold between frames. They change only with data_valid.
- Reset values:
  - csn=1, sclk=1
  - data=0, lead_err=0
  - data_valid=0, busy=0
  - state IDLE, counters 0
- Reset mid-frame aborts immediately. Asynchronous assertion forces csn/sclk high in the same instant. No partial data is published.

## Timing
- Cycle 0 is the first cycle with csn=0; csn falls one clk after the start condition in IDLE.
- First sclk fall: cycle CLK_DIV.
- Bit k is sampled at cycle CLK_DIV + 2*CLK_DIV*k + CLK_DIV.
- data_valid and csn rise: cycle CLK_DIV*(1 + 2*FRAME_BITS). With defaults this is cycle 132.
- Continuous frame period: CLK_DIV*(1 + 2*FRAME_BITS) + QUIET_CYC + 1 cycles. With defaults this is 141.
- busy deasserts when QUIET ends, in the same cycle the state returns to IDLE.
- SCLK frequency = f_clk / (2*CLK_DIV).

## Structure
- Package adc_capture_pkg holds:
  - state enum (IDLE/SETUP/SHIFT/QUIET)
  - FRAME_BITS derivation function
  - counter-width helper ($clog2 of max(CLK_DIV, QUIET_CYC, FRAME_BITS))
- Sub-module adc_sclk_gen: half-period counter producing sclk plus a one-cycle rise_stb/fall_stb, with clear.
- Top contains the FSM, the bit counter, and NUM_CH shift registers built by generate.

## Test plan
- Reset, enable=1, defaults, ADC model returning 0x0ABC on ch0 and 0x0123 on ch1:
  - data_valid first at cycle 132 after csn fall, data={0x123,0xABC}, lead_err=0
  - period 141 cycles
- enable=0, single trig pulse: exactly one frame, busy high 141 cycles, no second csn fall; a trig during that frame is ignored.
- Model drives 0x8FFF on ch0: data ch0=0xFFF, lead_err[0]=1, lead_err[1]=0.
- Assert rst at bit 7 of a frame: csn and sclk go to 1 immediately, data_valid never pulses, data=0; after release with enable=1, a clean frame follows.
- NUM_CH=4, DATA_W=10, LEAD_ZEROS=2, CLK_DIV=2:
  - channels 0x3FF/0x000/0x2AA/0x155 are captured in the correct slices
  - valid at cycle 2*(1+24)=50
- Drop enable at mid-SHIFT: that frame completes with valid, then state is IDLE after QUIET and csn stays high.

Source files
------------

// File: rtl/adc_serial_capture_pkg.sv
// adc_capture_pkg: shared types and sizing helpers for adc_serial_capture.
//   state_e       - capture FSM states
//   frame_bits()  - serial frame length (leading zeros + data bits)
//   cnt_width()   - width of the shared bit/quiet counter
package adc_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    QUIET
  } state_e;

  function automatic int frame_bits(input int lead_zeros, input int data_w);
    return lead_zeros + data_w;
  endfunction

  // The counter must hold the largest terminal value itself (the bit count
  // reaches FRAME_BITS, the quiet count reaches QUIET_CYC), hence the +1.
  function automatic int cnt_width(input int clk_div, input int quiet_cyc,
                                   input int frame_len);
    int m;
    m = clk_div;
    if (quiet_cyc > m) m = quiet_cyc;
    if (frame_len > m) m = frame_len;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/adc_serial_capture_if.sv
// adc_serial_capture_if: control, ADC pin and sample bus of the capture engine.
//   enable/trig          - conversion control (continuous / single shot)
//   adc_sdata            - one serial data line per channel
//   adc_sclk/adc_csn     - shared serial clock (idles high) and chip select
//   data/lead_err        - registered samples and leading-zero error flags
//   data_valid/busy      - publish strobe and frame-in-progress flag
// master = capture engine side, slave = system/ADC side.
interface adc_serial_capture_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 12
);
  logic                     enable;
  logic                     trig;
  logic [NUM_CH-1:0]        adc_sdata;
  logic                     adc_sclk;
  logic                     adc_csn;
  logic [NUM_CH*DATA_W-1:0] data;
  logic [NUM_CH-1:0]        lead_err;
  logic                     data_valid;
  logic                     busy;

  modport master (
    input  enable, trig, adc_sdata,
    output adc_sclk, adc_csn, data, lead_err, data_valid, busy
  );

  modport slave (
    output enable, trig, adc_sdata,
    input  adc_sclk, adc_csn, data, lead_err, data_valid, busy
  );
endinterface

// File: rtl/adc_serial_capture_sclk_gen.sv
// adc_sclk_gen: SCLK half-period generator.
//   clk, rst  - system clock, async active-high reset
//   clr       - hold counter at 0 and sclk high (takes priority)
//   sclk      - serial clock, CLK_DIV clk cycles per half period, idles high
//   rise_stb  - high in the cycle whose closing edge drives sclk high
//   fall_stb  - high in the cycle whose closing edge drives sclk low
module adc_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;

  // Strobes are not gated by clr so the parent can use them to decide clr.
  assign rise_stb = (cnt_q == LAST) && !sclk_q;
  assign fall_stb = (cnt_q == LAST) &&  sclk_q;
  assign sclk     = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (clr) begin
      cnt_d  = '0;
      sclk_d = 1'b1;
    end else if (cnt_q == LAST) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end
endmodule

// File: rtl/adc_serial_capture.sv
// adc_serial_capture: multi-channel capture engine for AD7476-class ADCs.
//   clk, rst  - system clock, async active-high reset
//   bus       - adc_serial_capture_if master: enable/trig in, ADC pins,
//               data/lead_err/data_valid/busy out
// One shared csn/sclk; NUM_CH data lines shifted in MSB-first on each sclk
// rise. Each frame is LEAD_ZEROS zero bits followed by DATA_W data bits.
module adc_serial_capture
  import adc_capture_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 12,
  parameter int LEAD_ZEROS = 4,
  parameter int CLK_DIV    = 4,
  parameter int QUIET_CYC  = 8
) (
  input logic                  clk,
  input logic                  rst,
  adc_serial_capture_if.master bus
);
  localparam int FRAME_BITS = frame_bits(LEAD_ZEROS, DATA_W);
  localparam int CNT_W      = cnt_width(CLK_DIV, QUIET_CYC, FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] QUIET_END = CNT_W'(QUIET_CYC);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_CH*DATA_W-1:0] data_q, data_d;
  logic [NUM_CH-1:0]        lead_err_q, lead_err_d;
  logic                     valid_q, valid_d;

  logic sclk, rise_stb, fall_stb, sclk_clr;
  logic shift_en, frame_end;

  logic [DATA_W-1:0] frame_data_a [NUM_CH];
  logic              frame_lz_a   [NUM_CH];

  adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk      (clk),
    .rst      (rst),
    .clr      (sclk_clr),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;

    always_comb begin
      shreg_d = shreg_q;
      if (shift_en) shreg_d = {shreg_q[FRAME_BITS-2:0], bus.adc_sdata[i]};
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) shreg_q <= '0;
      else     shreg_q <= shreg_d;
    end

    assign frame_data_a[i] = shreg_q[DATA_W-1:0];
    if (LEAD_ZEROS > 0) begin : g_lz
      assign frame_lz_a[i] = |shreg_q[FRAME_BITS-1:DATA_W];
    end else begin : g_no_lz
      assign frame_lz_a[i] = 1'b0;
    end
  end

  // The sclk generator is cleared outside SETUP/SHIFT and on the closing edge
  // of the last high phase, so sclk never glitches low as csn rises.
  assign sclk_clr = (state_q == IDLE) || (state_q == QUIET) || frame_end;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    lead_err_d = lead_err_q;
    valid_d    = 1'b0;
    shift_en   = 1'b0;
    frame_end  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.enable || bus.trig) state_d = SETUP;
      end
      SETUP: begin
        if (fall_stb) state_d = SHIFT;
      end
      SHIFT: begin
        if (rise_stb) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end else if (fall_stb && (cnt_q == LAST_BIT)) begin
          frame_end = 1'b1;
          cnt_d     = '0;
          valid_d   = 1'b1;
          state_d   = QUIET;
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            data_d[i*DATA_W +: DATA_W] = frame_data_a[i];
            lead_err_d[i]              = frame_lz_a[i];
          end
        end
      end
      QUIET: begin
        // Counts 0..QUIET_CYC inclusive: csn stays high QUIET_CYC+1 cycles,
        // giving the frame period CLK_DIV*(1+2*FRAME_BITS)+QUIET_CYC+1.
        if (cnt_q == QUIET_END) begin
          cnt_d   = '0;
          state_d = bus.enable ? SETUP : IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      lead_err_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      lead_err_q <= lead_err_d;
      valid_q    <= valid_d;
    end
  end

  // csn/busy decode the state register directly so async reset forces
  // csn high at once.
  assign bus.adc_csn    = (state_q == IDLE) || (state_q == QUIET);
  assign bus.busy       = (state_q != IDLE);
  assign bus.adc_sclk   = sclk;
  assign bus.data       = data_q;
  assign bus.lead_err   = lead_err_q;
  assign bus.data_valid = valid_q;
endmodule

// File: tb/tb_adc_serial_capture.sv
// tb_adc_serial_capture: directed bench for adc_serial_capture.
// DUT A uses the default parameters, DUT B uses NUM_CH=4, DATA_W=10,
// LEAD_ZEROS=2, CLK_DIV=2. Each has a behavioural ADC that presents the next
// frame bit (MSB first) shortly after every sclk fall while csn is low.
module tb_adc_serial_capture;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_serial_capture_if #(.NUM_CH(2), .DATA_W(12)) a_if ();
  adc_serial_capture_if #(.NUM_CH(4), .DATA_W(10)) b_if ();

  adc_serial_capture #(
    .NUM_CH(2), .DATA_W(12), .LEAD_ZEROS(4), .CLK_DIV(4), .QUIET_CYC(8)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  adc_serial_capture #(
    .NUM_CH(4), .DATA_W(10), .LEAD_ZEROS(2), .CLK_DIV(2), .QUIET_CYC(8)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  // ADC models: a csn fall (sclk high) restarts the frame; each sclk fall
  // presents the next bit.
  logic [15:0] word_a [2];
  int          falls_a = 0;
  always @(negedge a_if.adc_csn or negedge a_if.adc_sclk) begin
    if (a_if.adc_sclk) begin
      falls_a = 0;
    end else if (!a_if.adc_csn && falls_a < 16) begin
      #1;
      for (int ch = 0; ch < 2; ch++) a_if.adc_sdata[ch] = word_a[ch][15-falls_a];
      falls_a++;
    end
  end

  logic [11:0] word_b [4];
  int          falls_b = 0;
  always @(negedge b_if.adc_csn or negedge b_if.adc_sclk) begin
    if (b_if.adc_sclk) begin
      falls_b = 0;
    end else if (!b_if.adc_csn && falls_b < 12) begin
      #1;
      for (int ch = 0; ch < 4; ch++) b_if.adc_sdata[ch] = word_b[ch][11-falls_b];
      falls_b++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // sel: 0 A csn low, 1 A data_valid, 2 B csn low, 3 B data_valid.
  task automatic wait_for(input int sel, input int bound, output int t);
    bit seen;
    seen = 1'b0;
    t = -1;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      case (sel)
        0: seen = !a_if.adc_csn;
        1: seen = a_if.data_valid;
        2: seen = !b_if.adc_csn;
        3: seen = b_if.data_valid;
        default: seen = 1'b0;
      endcase
      if (seen) t = cyc;
    end
    chk($sformatf("wait%0d_seen", sel), 64'(seen), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_en, t0, t1, t2, t3, t4, t5, tv, tb0, tbv;
    int t_idle, lowc, busyc, fallc, validc;
    logic csn_prev;

    a_if.enable = 1'b0; a_if.trig = 1'b0;
    b_if.enable = 1'b0; b_if.trig = 1'b0;
    word_a[0] = 16'h0ABC; word_a[1] = 16'h0123;
    word_b[0] = 12'h3FF;  word_b[1] = 12'h000;
    word_b[2] = 12'h2AA;  word_b[3] = 12'h155;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_csn",      64'(a_if.adc_csn),    64'd1);
    chk("rst_sclk",     64'(a_if.adc_sclk),   64'd1);
    chk("rst_data",     64'(a_if.data),       64'd0);
    chk("rst_lead_err", 64'(a_if.lead_err),   64'd0);
    chk("rst_valid",    64'(a_if.data_valid), 64'd0);
    chk("rst_busy",     64'(a_if.busy),       64'd0);

    // Continuous conversion, first frame timing and data
    rst = 1'b0;
    @(negedge clk);
    t_en = cyc;
    a_if.enable = 1'b1;
    wait_for(0, 20, t0);
    chk("csn_fall_latency", 64'(t0 - t_en), 64'd1);
    wait_for(1, 200, tv);
    chk("valid_cycle",     64'(tv - t0),         64'd132);
    chk("data_frame1",     64'(a_if.data),       64'h123ABC);
    chk("lead_err_frame1", 64'(a_if.lead_err),   64'd0);
    chk("csn_at_valid",    64'(a_if.adc_csn),    64'd1);
    @(negedge clk);
    chk("valid_one_cycle", 64'(a_if.data_valid), 64'd0);
    word_a[0] = 16'h8FFF;
    wait_for(0, 20, t1);
    chk("frame_period", 64'(t1 - t0), 64'd141);

    // Leading-zero error on ch0
    wait_for(1, 200, tv);
    chk("data_lz_frame",     64'(a_if.data),     64'h123FFF);
    chk("lead_err_lz_frame", 64'(a_if.lead_err), 64'h1);
    word_a[0] = 16'h0ABC;

    // Drop enable mid-SHIFT: frame completes, then IDLE
    wait_for(0, 20, t2);
    repeat (60) @(negedge clk);
    a_if.enable = 1'b0;
    wait_for(1, 200, tv);
    chk("drop_en_valid_cycle", 64'(tv - t2),       64'd132);
    chk("drop_en_data",        64'(a_if.data),     64'h123ABC);
    chk("drop_en_lead_err",    64'(a_if.lead_err), 64'd0);
    t_idle = -1;
    lowc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!a_if.busy && t_idle < 0) t_idle = cyc;
      if (!a_if.adc_csn) lowc++;
    end
    chk("idle_after_quiet", 64'(t_idle - tv), 64'd9);
    chk("no_restart",       64'(lowc),        64'd0);

    // Single shot; trig pulses in SHIFT and QUIET are ignored
    a_if.trig = 1'b1;
    @(negedge clk);
    a_if.trig = 1'b0;
    t3 = cyc;
    chk("trig_csn_low", 64'(a_if.adc_csn), 64'd0);
    busyc = a_if.busy ? 1 : 0;
    fallc = 0;
    validc = 0;
    csn_prev = a_if.adc_csn;
    for (int i = 1; i < 400; i++) begin
      @(negedge clk);
      a_if.trig = (i == 50 || i == 135);
      if (a_if.busy) busyc++;
      if (csn_prev && !a_if.adc_csn) fallc++;
      if (a_if.data_valid) validc++;
      csn_prev = a_if.adc_csn;
    end
    a_if.trig = 1'b0;
    chk("shot_busy_cycles", 64'(busyc),     64'd141);
    chk("shot_no_refire",   64'(fallc),     64'd0);
    chk("shot_one_valid",   64'(validc),    64'd1);
    chk("shot_data",        64'(a_if.data), 64'h123ABC);

    // Reset during bit 7 low phase
    a_if.enable = 1'b1;
    wait_for(0, 20, t4);
    repeat (62) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_csn",      64'(a_if.adc_csn),  64'd1);
    chk("midrst_sclk",     64'(a_if.adc_sclk), 64'd1);
    chk("midrst_data",     64'(a_if.data),     64'd0);
    chk("midrst_lead_err", 64'(a_if.lead_err), 64'd0);
    chk("midrst_busy",     64'(a_if.busy),     64'd0);
    validc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_if.data_valid) validc++;
    end
    chk("midrst_no_valid", 64'(validc), 64'd0);
    rst = 1'b0;
    t_en = cyc;
    wait_for(0, 20, t5);
    chk("postrst_latency", 64'(t5 - t_en), 64'd1);
    wait_for(1, 200, tv);
    chk("postrst_valid_cycle", 64'(tv - t5),   64'd132);
    chk("postrst_data",        64'(a_if.data), 64'h123ABC);
    a_if.enable = 1'b0;

    // Four-channel configuration
    @(negedge clk);
    t_en = cyc;
    b_if.enable = 1'b1;
    wait_for(2, 20, tb0);
    chk("b_csn_latency", 64'(tb0 - t_en), 64'd1);
    wait_for(3, 100, tbv);
    chk("b_valid_cycle", 64'(tbv - tb0), 64'd50);
    chk("b_data",        64'(b_if.data), 64'({10'h155, 10'h2AA, 10'h000, 10'h3FF}));
    chk("b_lead_err",    64'(b_if.lead_err), 64'd0);
    b_if.enable = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
